// File: rtl/axi4lite_wb_bridge.sv
// AXI4-lite responder that turns each AXI4-lite transaction into a single
// Wishbone pipelined-mode initiator cycle, one transaction outstanding.
module axi4lite_wb_bridge #(
    parameter int ADDR_WIDTH = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  awvalid_i,
    output logic                  awready_o,
    input  logic [ADDR_WIDTH-1:0] awaddr_i,
    input  logic [2:0]            awprot_i,
    input  logic                  wvalid_i,
    output logic                  wready_o,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            wstrb_i,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [1:0]            bresp_o,
    input  logic                  arvalid_i,
    output logic                  arready_o,
    input  logic [ADDR_WIDTH-1:0] araddr_i,
    input  logic [2:0]            arprot_i,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [31:0]           rdata_o,
    output logic [1:0]            rresp_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [ADDR_WIDTH-3:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                state;
    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic                  cur_write;
    logic                  prefer_write;
    logic [CW-1:0]         cnt;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_elig, rd_elig, pick_write;
    logic [ADDR_WIDTH-1:0] aw_addr_n, ar_addr_n;
    logic [31:0]           w_data_n;
    logic [3:0]            w_strb_n;
    logic                  in_cyc, term, done_ok, timeout_hit, abort, finish, resp_err;
    logic                  unused;

    assign awready_o = ~aw_full;
    assign wready_o  = ~w_full;
    assign arready_o = ~ar_full;

    assign aw_hs = awvalid_i & ~aw_full;
    assign w_hs  = wvalid_i & ~w_full;
    assign ar_hs = arvalid_i & ~ar_full;

    // Eligibility looks through an incoming handshake so a request can start
    // on the same edge that completes its capture.
    assign wr_elig    = (aw_full | aw_hs) & (w_full | w_hs);
    assign rd_elig    = ar_full | ar_hs;
    assign pick_write = wr_elig & (~rd_elig | prefer_write);

    assign aw_addr_n = aw_full ? aw_addr : awaddr_i;
    assign ar_addr_n = ar_full ? ar_addr : araddr_i;
    assign w_data_n  = w_full ? w_data : wdata_i;
    assign w_strb_n  = w_full ? w_strb : wstrb_i;

    assign in_cyc      = (state == REQ) || (state == WAIT);
    assign term        = wb_ack_i | wb_err_i | wb_rty_i;
    // Terminations only count once the strobe has been accepted.
    assign done_ok     = term && ((state == WAIT) || ((state == REQ) && !wb_stall_i));
    assign timeout_hit = (TIMEOUT != 0) && ({{(32-CW){1'b0}}, cnt} == 32'(TIMEOUT - 1));
    assign abort       = in_cyc && !done_ok && timeout_hit;
    assign finish      = done_ok | abort;
    assign resp_err    = abort | wb_err_i | wb_rty_i;

    assign unused = ^{awprot_i, arprot_i, aw_addr_n[1:0], ar_addr_n[1:0]};

    // Capture buffer occupancy: set on handshake, cleared when the served request terminates.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            ar_full <= 1'b0;
        end else begin
            if (aw_hs) aw_full <= 1'b1;
            if (w_hs)  w_full  <= 1'b1;
            if (ar_hs) ar_full <= 1'b1;
            if (finish) begin
                if (cur_write) begin
                    aw_full <= 1'b0;
                    w_full  <= 1'b0;
                end else begin
                    ar_full <= 1'b0;
                end
            end
        end
    end

    // Capture buffer contents, written only while the matching buffer is empty.
    always_ff @(posedge clk_i) begin
        if (aw_hs) aw_addr <= awaddr_i;
        if (ar_hs) ar_addr <= araddr_i;
        if (w_hs) begin
            w_data <= w_data_n;
            w_strb <= w_strb_n;
        end
    end

    // Transaction FSM with registered Wishbone and AXI response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            bvalid_o     <= 1'b0;
            rvalid_o     <= 1'b0;
            bresp_o      <= 2'b00;
            rresp_o      <= 2'b00;
            rdata_o      <= 32'h0;
            prefer_write <= 1'b1;
            cur_write    <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_elig || rd_elig) begin
                        state     <= REQ;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        cnt       <= '0;
                        cur_write <= pick_write;
                        wb_we_o   <= pick_write;
                        wb_adr_o  <= pick_write ? aw_addr_n[ADDR_WIDTH-1:2] : ar_addr_n[ADDR_WIDTH-1:2];
                        wb_sel_o  <= pick_write ? w_strb_n : 4'hF;
                        wb_dat_o  <= w_data_n;
                        // Fairness pointer only moves when both types competed.
                        if (wr_elig && rd_elig) prefer_write <= ~pick_write;
                    end
                end
                REQ, WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (finish) begin
                        state    <= RESP;
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (cur_write) begin
                            bvalid_o <= 1'b1;
                            bresp_o  <= resp_err ? 2'b10 : 2'b00;
                        end else begin
                            rvalid_o <= 1'b1;
                            rresp_o  <= resp_err ? 2'b10 : 2'b00;
                            rdata_o  <= resp_err ? 32'h0 : wb_dat_i;
                        end
                    end else if (state == REQ && !wb_stall_i) begin
                        state    <= WAIT;
                        wb_stb_o <= 1'b0;
                    end
                end
                RESP: begin
                    if ((bvalid_o && bready_i) || (rvalid_o && rready_i)) begin
                        state    <= IDLE;
                        bvalid_o <= 1'b0;
                        rvalid_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4lite_wb_bridge.md
Name: axi4lite_wb_bridge

Overview:
- AXI4-lite responder that converts each AXI4-lite transaction into one Wishbone pipelined-mode initiator cycle.
- It is the inverse of the Wishbone-to-AXI4-lite submap path: an AXI4-lite fabric reaches a Wishbone-only register bank through it.
- One Wishbone transaction is outstanding at a time. Data width is 32 bits, fixed.

Parameters:
ADDR_WIDTH, 3, AXI byte-address width (at least 3); Wishbone word address is addr[ADDR_WIDTH-1:2].
TIMEOUT, 255, cycles with cyc high and no ack/err/rty before the bridge aborts with SLVERR; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
awvalid_i  in  1  AXI write-address valid
awready_o  out  1  AXI write-address ready
awaddr_i  in  ADDR_WIDTH  AXI write byte address
awprot_i  in  3  AXI write protection; ignored
wvalid_i  in  1  AXI write-data valid
wready_o  out  1  AXI write-data ready
wdata_i  in  32  AXI write data
wstrb_i  in  4  AXI write byte strobes
bvalid_o  out  1  AXI write-response valid
bready_i  in  1  AXI write-response ready
bresp_o  out  2  AXI write response
arvalid_i  in  1  AXI read-address valid
arready_o  out  1  AXI read-address ready
araddr_i  in  ADDR_WIDTH  AXI read byte address
arprot_i  in  3  AXI read protection; ignored
rvalid_o  out  1  AXI read-data valid
rready_i  in  1  AXI read-data ready
rdata_o  out  32  AXI read data
rresp_o  out  2  AXI read response
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_adr_o  out  ADDR_WIDTH-2  Wishbone word address
wb_sel_o  out  4  Wishbone byte selects
wb_we_o  out  1  Wishbone write enable
wb_dat_o  out  32  Wishbone write data
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
wb_rty_i  in  1  Wishbone retry
wb_stall_i  in  1  Wishbone stall
wb_dat_i  in  32  Wishbone read data

Behaviour:
- All state is registered. The reset is sampled on the rising edge of clk_i.
- State after reset: all valid, cyc and stb outputs = 0; bresp/rresp = 2'b00; rdata = 0; awready/wready/arready = 1 (capture buffers empty).
- Capture buffers: independent one-entry AW, W and AR buffers.
  - Each xready_o = buffer empty.
  - A handshake (valid & ready) loads the buffer. AW and W may arrive in either order or in the same cycle.
- Arbitration: in IDLE, a write is eligible when both AW and W are full; a read is eligible when AR is full.
  - If both are eligible, the request type not served last wins. Write wins first after reset.
- FSM states: IDLE -> REQ -> WAIT -> RESP -> IDLE.
  - REQ: cyc=1, stb=1, adr/sel/we/dat driven from the chosen buffer.
    - Reads drive sel=4'hF.
    - Writes drive sel=wstrb and dat=wdata.
  - Leave REQ when wb_stall_i=0.
    - If ack/err/rty is sampled in that same cycle, go straight to RESP.
    - Otherwise go to WAIT with stb=0 and cyc=1.
  - WAIT: hold cyc until ack/err/rty, then go to RESP.
  - Termination sampling:
    - On any termination, cyc drops in the following cycle.
    - Read data is captured from wb_dat_i on the ack cycle.
    - The consumed buffer(s) are cleared on termination, so ready re-asserts on the next cycle.
  - RESP: bvalid_o or rvalid_o is held with resp/data stable until the matching ready, then go to IDLE. Ready may already be high when valid rises.
- Response coding:
  - ack -> 2'b00.
  - err or rty -> 2'b10 (SLVERR); rdata = 0.
  - ack and err in the same cycle -> err takes precedence.
- Timeout:
  - A counter clears when the bridge enters REQ and increments every cycle that cyc=1.
  - Reaching TIMEOUT in REQ or WAIT forces termination with SLVERR and rdata = 0.
  - A Wishbone response arriving after the abort is ignored.
- Latency, with stall=0 and ack in the first strobe cycle:
  - Handshake completes at cycle T; stb=1 at T+1; valid response at T+2.
  - Back-to-back: the next transaction's stb occurs at the earliest one cycle after the response handshake.
- Capture during a transaction: AW/W/AR may be accepted at any time, including during a transaction, if the buffer is empty. Its contents are untouched until served.
- Reset mid-transaction: cyc/stb and all valids are 0 on the cycle after reset is sampled. Pending buffers are discarded.

Test Plan:
- Write 0xDEADBEEF to byte address 0x4 with wstrb=4'b0101, AW at T and W at T+2; ack at first stb -> wb_adr_o=1, wb_sel_o=4'b0101, wb_we_o=1, stb at T+3, bvalid at T+4 with bresp=00.
- Read address 0x0; stall high for 3 cycles, then ack with wb_dat_i=0x12345678 -> stb held 4 cycles, rvalid with rdata=0x12345678, rresp=00; with rready low for 5 cycles, rdata stays stable throughout.
- Write and read both eligible in the same IDLE cycle after reset -> write served first, then the read; a second simultaneous pair -> read served first.
- wb_err_i on a read -> rresp=2'b10, rdata=0; wb_rty_i on a write -> bresp=2'b10.
- TIMEOUT=8, no ack -> cyc drops after 8 cycles, SLVERR response; an ack injected afterwards produces no extra response.
- Reset asserted during WAIT -> next cycle cyc=0, bvalid=rvalid=0, all readies=1; a new read afterwards completes normally.
